// File: rtl/pillar_field.sv
// pillar_field: scrolling pillar obstacle generator with LFSR gap placement, scoring and sticky collision.
// Optional difficulty ramp (level, speed, shrinking gap) is built only when PILLAR_DIFFICULTY_RAMP_EN is defined.
module pillar_field #(
  parameter int          COUNT       = 4,
  parameter int          XW          = 11,
  parameter int          YW          = 10,
  parameter int          SW          = 10,
  parameter int          X_INIT      = 640,
  parameter int          SPACING     = 200,
  parameter int          PILLAR_W    = 50,
  parameter int          BIRD_X      = 100,
  parameter int          BIRD_W      = 24,
  parameter int          BIRD_H      = 18,
  parameter int          Y_MIN       = 60,
  parameter int          RAND_BITS   = 7,
  parameter int          GAP_INIT    = 128,
  parameter int          GAP_MIN     = 72,
  parameter int          GAP_STEP    = 8,
  parameter int          SPEED_INIT  = 1,
  parameter int          SPEED_MAX   = 4,
  parameter int          LEVEL_SCORE = 5,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                frame_clk,
  input  logic                rstn,
  input  logic [1:0]          state,
  input  logic                pause,
  input  logic [YW-1:0]       bird_y,
  output logic [COUNT*XW-1:0] pillar_x_bus,
  output logic [COUNT*YW-1:0] gap_y_bus,
  output logic [COUNT*YW-1:0] gap_h_bus,
  output logic [SW-1:0]       score,
  output logic                score_pulse,
  output logic [3:0]          level,
  output logic [2:0]          speed,
  output logic                hit
);

  localparam logic [1:0]    ST_INIT    = 2'b00;
  localparam logic [1:0]    ST_RUN     = 2'b01;
  localparam int            PW         = $clog2(COUNT + 1);
  localparam logic [YW-1:0] GAP_Y_INIT = YW'(Y_MIN + 2**(RAND_BITS - 1));
  localparam logic [SW:0]   SCORE_MAX  = {1'b0, {SW{1'b1}}};

  logic [XW-1:0]    r_x     [COUNT];
  logic [YW-1:0]    r_gap_y [COUNT];
  logic [YW-1:0]    r_gap_h [COUNT];
  logic [COUNT-1:0] r_passed;
  logic [SW-1:0]    r_score;
  logic             r_pulse;
  logic             r_hit;
  logic [15:0]      r_lfsr;

  logic             w_run;
  logic [2:0]       w_speed;
  logic [3:0]       w_level;
  logic [YW-1:0]    w_gap_spawn;
  logic [XW:0]      w_speed_x;
  logic [XW:0]      w_x_dec   [COUNT];
  logic [XW-1:0]    w_x_nxt   [COUNT];
  logic [YW-1:0]    w_gy_nxt  [COUNT];
  logic [YW-1:0]    w_gh_nxt  [COUNT];
  logic [COUNT-1:0] w_passed_nxt;
  logic [PW-1:0]    w_passes;
  logic [SW:0]      w_score_sum;
  logic [SW-1:0]    w_score_nxt;
  logic [COUNT-1:0] w_hov;
  logic [COUNT-1:0] w_vov;
  logic             w_collide;
  logic [15:0]      w_lfsr_nxt;

  function automatic logic [XW-1:0] f_x_init(input int idx);
    return XW'(X_INIT + SPACING * idx);
  endfunction

`ifdef PILLAR_DIFFICULTY_RAMP_EN
  localparam int GW = YW + 5;

  logic [3:0]    r_level;
  logic [3:0]    w_level_nxt;
  logic [SW-1:0] w_div;
  logic [4:0]    w_spd_sum;
  logic [GW-1:0] w_gap_dec;

  always_comb begin
    w_div       = w_score_nxt / SW'(LEVEL_SCORE);
    w_level_nxt = (w_div > SW'(15)) ? 4'd15 : w_div[3:0];
    w_spd_sum   = 5'(SPEED_INIT) + {1'b0, r_level};
    w_speed     = (w_spd_sum > 5'(SPEED_MAX)) ? 3'(SPEED_MAX) : w_spd_sum[2:0];
    w_gap_dec   = GW'(r_level) * GW'(GAP_STEP);
    // compare as dec+min >= init so the subtraction below never underflows
    w_gap_spawn = ((w_gap_dec + GW'(GAP_MIN)) >= GW'(GAP_INIT)) ?
                  YW'(GAP_MIN) : YW'(GW'(GAP_INIT) - w_gap_dec);
  end

  assign w_level = r_level;

  always_ff @(posedge frame_clk or negedge rstn) begin
    if (!rstn) begin
      r_level <= '0;
    end else if (state == ST_INIT) begin
      r_level <= '0;
    end else if (w_run) begin
      r_level <= w_level_nxt;
    end
  end
`else
  assign w_level     = 4'd0;
  assign w_speed     = 3'(SPEED_INIT);
  assign w_gap_spawn = YW'(GAP_INIT);
`endif

  assign w_run      = (state == ST_RUN) && !pause;
  assign w_speed_x  = (XW+1)'(w_speed);
  assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    w_passes     = '0;
    w_passed_nxt = r_passed;
    for (int i = 0; i < COUNT; i++) begin
      w_x_dec[i]  = {1'b0, r_x[i]} - w_speed_x;
      w_x_nxt[i]  = w_x_dec[i][XW-1:0];
      w_gy_nxt[i] = r_gap_y[i];
      w_gh_nxt[i] = r_gap_h[i];
      if ({1'b0, r_x[i]} <= w_speed_x) begin
        // respawn behind the previous pillar, using its pre-edge position
        w_x_nxt[i]      = XW'({1'b0, r_x[(i + COUNT - 1) % COUNT]} + (XW+1)'(SPACING) - w_speed_x);
        w_gy_nxt[i]     = YW'(Y_MIN) + YW'(r_lfsr[RAND_BITS-1:0]);
        w_gh_nxt[i]     = w_gap_spawn;
        w_passed_nxt[i] = 1'b0;
      end else if ((w_x_dec[i] <= (XW+1)'(BIRD_X)) && !r_passed[i]) begin
        w_passed_nxt[i] = 1'b1;
        w_passes        = w_passes + PW'(1);
      end
    end
  end

  always_comb begin
    w_score_sum = {1'b0, r_score} + (SW+1)'(w_passes);
    w_score_nxt = (w_score_sum > SCORE_MAX) ? {SW{1'b1}} : w_score_sum[SW-1:0];
  end

  always_comb begin
    w_hov     = '0;
    w_vov     = '0;
    w_collide = 1'b0;
    for (int i = 0; i < COUNT; i++) begin
      w_hov[i]  = ({1'b0, r_x[i]} > (XW+1)'(BIRD_X)) &&
                  (({1'b0, r_x[i]} - (XW+1)'(PILLAR_W)) < (XW+1)'(BIRD_X + BIRD_W));
      w_vov[i]  = ({1'b0, bird_y} < {1'b0, r_gap_y[i]}) ||
                  (({1'b0, bird_y} + (YW+1)'(BIRD_H)) > ({1'b0, r_gap_y[i]} + {1'b0, r_gap_h[i]}));
      w_collide = w_collide | (w_hov[i] & w_vov[i]);
    end
  end

  always_ff @(posedge frame_clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < COUNT; i++) begin
        r_x[i]     <= f_x_init(i);
        r_gap_y[i] <= GAP_Y_INIT;
        r_gap_h[i] <= YW'(GAP_INIT);
      end
      r_passed <= '0;
      r_score  <= '0;
      r_pulse  <= 1'b0;
      r_hit    <= 1'b0;
      r_lfsr   <= SEED;
    end else begin
      // the LFSR free-runs in every state so INIT never reseeds it
      r_lfsr <= w_lfsr_nxt;
      if (state == ST_INIT) begin
        for (int i = 0; i < COUNT; i++) begin
          r_x[i]     <= f_x_init(i);
          r_gap_y[i] <= GAP_Y_INIT;
          r_gap_h[i] <= YW'(GAP_INIT);
        end
        r_passed <= '0;
        r_score  <= '0;
        r_pulse  <= 1'b0;
        r_hit    <= 1'b0;
      end else if (w_run) begin
        for (int i = 0; i < COUNT; i++) begin
          r_x[i]     <= w_x_nxt[i];
          r_gap_y[i] <= w_gy_nxt[i];
          r_gap_h[i] <= w_gh_nxt[i];
        end
        r_passed <= w_passed_nxt;
        r_score  <= w_score_nxt;
        r_pulse  <= (w_passes != '0);
        r_hit    <= r_hit | w_collide;
      end else begin
        r_pulse <= 1'b0;
      end
    end
  end

  always_comb begin
    pillar_x_bus = '0;
    gap_y_bus    = '0;
    gap_h_bus    = '0;
    for (int i = 0; i < COUNT; i++) begin
      pillar_x_bus[i*XW +: XW] = r_x[i];
      gap_y_bus[i*YW +: YW]    = r_gap_y[i];
      gap_h_bus[i*YW +: YW]    = r_gap_h[i];
    end
  end

  assign score       = r_score;
  assign score_pulse = r_pulse;
  assign level       = w_level;
  assign speed       = w_speed;
  assign hit         = r_hit;

endmodule
